// File: rtl/proc_trace_fifo_pkg.sv
// ----------------------------------------------------------------------------
// proc_trace_pkg
// Shared types for the processor commit-trace buffer.
//   TRACE_ENTRY_W : width of one stored trace entry (PC + writeback data)
//   trace_entry_t : packed view of one entry, PC in the upper half
// ----------------------------------------------------------------------------
package proc_trace_pkg;

    parameter int TRACE_ENTRY_W = 64;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } trace_entry_t;

endpackage

// File: rtl/proc_trace_fifo_if.sv
// ----------------------------------------------------------------------------
// proc_trace_fifo_if
// Trace input (no backpressure) plus val/rdy dequeue side of the trace FIFO.
//   trace_val/trace_addr/trace_data : commit trace from the processor
//   deq_val/deq_addr/deq_data       : head entry presented to the consumer
//   deq_rdy                         : consumer accepts the head entry
// master : the producer/consumer side (processor + drain logic, or a bench)
// slave  : the FIFO itself
// ----------------------------------------------------------------------------
interface proc_trace_fifo_if;

    logic        trace_val;
    logic [31:0] trace_addr;
    logic [31:0] trace_data;
    logic        deq_val;
    logic        deq_rdy;
    logic [31:0] deq_addr;
    logic [31:0] deq_data;

    modport master (
        output trace_val, trace_addr, trace_data, deq_rdy,
        input  deq_val, deq_addr, deq_data
    );

    modport slave (
        input  trace_val, trace_addr, trace_data, deq_rdy,
        output deq_val, deq_addr, deq_data
    );

endinterface

// File: rtl/proc_trace_fifo_mem.sv
// ----------------------------------------------------------------------------
// trace_fifo_mem
// DEPTH x TRACE_ENTRY_W register file backing the trace FIFO.
//   clk     : clock
//   i_we    : write enable
//   i_waddr : write index
//   i_wdata : entry to store
//   i_raddr : read index
//   o_rdata : combinational read of r_mem[i_raddr]
// Storage is deliberately not reset; the top level masks the read data
// whenever the FIFO is empty, so stale contents never reach the consumer.
// ----------------------------------------------------------------------------
module trace_fifo_mem
    import proc_trace_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       i_we,
    input  logic [$clog2(DEPTH)-1:0]   i_waddr,
    input  logic [TRACE_ENTRY_W-1:0]   i_wdata,
    input  logic [$clog2(DEPTH)-1:0]   i_raddr,
    output logic [TRACE_ENTRY_W-1:0]   o_rdata
);

    logic [TRACE_ENTRY_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/proc_trace_fifo.sv
// ----------------------------------------------------------------------------
// proc_trace_fifo
// Buffers the processor commit trace so a slower consumer can drain it over
// a val/rdy interface. The processor cannot be stalled, so entries arriving
// while the buffer is full (and not draining that cycle) are dropped and
// counted.
//   clk, rst   : clock, asynchronous active-high reset
//   bus        : proc_trace_fifo_if.slave (trace in, val/rdy dequeue out)
//   clear      : synchronous clear of overflow and drop_count only
//   count      : current occupancy (0..DEPTH)
//   overflow   : sticky, set on any drop since reset/clear
//   drop_count : saturating count of dropped entries
// ----------------------------------------------------------------------------
module proc_trace_fifo
    import proc_trace_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int DROPW = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    proc_trace_fifo_if.slave         bus,
    input  logic                     clear,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [DROPW-1:0]         drop_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]            r_headPtr;
    logic [AW-1:0]            r_tailPtr;
    logic [CW-1:0]            r_count;
    logic                     r_overflow;
    logic [DROPW-1:0]         r_dropCount;

    logic                     w_notEmpty;
    logic                     w_full;
    logic                     w_deqFire;
    logic                     w_enq;
    logic                     w_drop;
    trace_entry_t             w_wentry;
    trace_entry_t             w_rentry;
    logic [TRACE_ENTRY_W-1:0] w_rdata;

    // A full buffer can still accept a new entry when the head leaves in the
    // same cycle; only a full, non-draining cycle loses the incoming trace.
    assign w_notEmpty = (r_count != '0);
    assign w_full     = (r_count == CW'(DEPTH));
    assign w_deqFire  = w_notEmpty && bus.deq_rdy;
    assign w_enq      = bus.trace_val && (!w_full || w_deqFire);
    assign w_drop     = bus.trace_val && w_full && !w_deqFire;

    assign w_wentry = '{addr: bus.trace_addr, data: bus.trace_data};

    trace_fifo_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_enq),
        .i_waddr (r_tailPtr),
        .i_wdata (w_wentry),
        .i_raddr (r_headPtr),
        .o_rdata (w_rdata)
    );

    assign w_rentry = trace_entry_t'(w_rdata);

    // Head entry is masked to zero while empty so unreset storage is never
    // visible on the outputs.
    assign bus.deq_val  = w_notEmpty;
    assign bus.deq_addr = w_notEmpty ? w_rentry.addr : 32'h0;
    assign bus.deq_data = w_notEmpty ? w_rentry.data : 32'h0;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_headPtr <= '0;
            r_tailPtr <= '0;
            r_count   <= '0;
        end else begin
            if (w_enq) begin
                r_tailPtr <= r_tailPtr + AW'(1);
            end
            if (w_deqFire) begin
                r_headPtr <= r_headPtr + AW'(1);
            end
            case ({w_enq, w_deqFire})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // A drop in the same cycle as clear takes priority, so the drop that
    // happened is never lost from the statistics.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_dropCount <= '0;
        end else if (clear) begin
            r_overflow  <= w_drop;
            r_dropCount <= w_drop ? DROPW'(1) : '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_dropCount != '1) begin
                r_dropCount <= r_dropCount + DROPW'(1);
            end
        end
    end

    assign count      = r_count;
    assign overflow   = r_overflow;
    assign drop_count = r_dropCount;

endmodule

// File: doc/proc_trace_fifo.md
Name: proc_trace_fifo

Overview:
- Buffers the processor commit trace (trace_val/trace_addr/trace_data) so a slower consumer can drain it through a val/rdy interface. Consumers include a UART dumper, the bench checker, and the FPGA debug port.
- Sits directly downstream of ProcScycle's trace outputs.
- The processor cannot be stalled, so the input side has no backpressure. Entries that arrive while the buffer is full are dropped and counted.

Parameters:
- DEPTH, 8, number of entries; power of two, minimum 2.
- DROPW, 16, width of the saturating drop counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- trace_val  in  1  processor committed an instruction this cycle
- trace_addr  in  32  PC of the committed instruction
- trace_data  in  32  writeback data; may be X for non-writing instructions
- clear  in  1  synchronous clear of overflow and drop_count only
- deq_val  out  1  head entry valid
- deq_rdy  in  1  consumer accepts the head entry
- deq_addr  out  32  head entry PC
- deq_data  out  32  head entry data
- count  out  $clog2(DEPTH)+1  current occupancy
- overflow  out  1  sticky; at least one entry dropped since reset or clear
- drop_count  out  DROPW  number of dropped entries, saturating

Behaviour:
- Reset (async assert, any cycle, including mid-drain):
  - Pointers, count, overflow and drop_count go to 0; deq_val=0.
  - deq_addr and deq_data are 0 while empty. Storage contents are don't-care.
- enq = trace_val && (!full || deq_fire), where deq_fire = deq_val && deq_rdy and full = (count==DEPTH).
- Dequeue occurs on deq_fire. The head advances at the clock edge.
- Latency: an entry written at edge N is visible on deq_* after edge N (from cycle N+1). There is no same-cycle bypass.
- Ordering: strict FIFO order. Pointers wrap modulo DEPTH.
- count next value:
  - count+1 when enq only
  - count-1 when deq_fire only
  - unchanged when both or neither
- Full, trace_val=1, deq_fire=1: the incoming entry is accepted, the head leaves, count stays DEPTH, and no drop occurs.
- Full, trace_val=1, deq_fire=0: the entry is dropped.
  - overflow<=1.
  - drop_count<=drop_count+1, saturating at all-ones.
- Empty with deq_rdy=1: no effect. deq_val stays 0 until the cycle after the first enq.
- deq_* registered outputs come from storage[head]. They are held stable while deq_val=1 && deq_rdy=0.
- Input trace_data=X is stored and replayed as X. This is not an error.
- clear=1 zeroes overflow and drop_count at the next edge.
  - If a drop occurs in the same cycle, the drop wins: overflow=1, drop_count=1.
  - clear does not touch FIFO contents.
- No state machine beyond the pointer/count datapath. Empty is count==0.

Decomposition:
- Package proc_trace_pkg:
  - typedef struct packed {logic [31:0] addr; logic [31:0] data;} trace_entry_t.
  - Parameter TRACE_ENTRY_W=64.
- One sub-module, trace_fifo_mem: a DEPTH x TRACE_ENTRY_W register file.
  - One synchronous write port, one combinational read port.
  - No reset on storage.
- Top level holds the pointers, count, overflow logic and drop counter.

Test Plan:
- Single pass-through: trace (0x200,0x5) at cycle 1 with deq_rdy=1 -> deq_val=1, deq_addr=0x200, deq_data=0x5 in cycle 2; count 1 then 0; overflow=0.
- Fill and order: 8 traces (PC 0x200..0x21C, data = index) with deq_rdy=0 -> count=8. Then deq_rdy=1 for 8 cycles -> entries emerge in order with no gaps, and count returns to 0.
- Overflow: fill 8, then 3 more traces with deq_rdy=0 -> overflow=1, drop_count=3. After draining, the first 8 entries are intact and the three extra PCs never appear.
- Full with simultaneous enq/deq: full and deq_rdy=1 with continuous traces for 20 cycles -> count stays 8, drop_count=0, output sequence is gap-free and monotonic.
- Clear and saturation: with DROPW=4, drop 20 entries -> drop_count=15. Then clear alone -> 0. Then clear together with a drop -> drop_count=1, overflow=1.
- Async reset mid-drain: with count=5 and deq_rdy toggling, assert rst between clock edges -> deq_val, count, overflow and drop_count read 0 immediately. After release, a new trace 0x300 is the first entry out.
